pcecd_cmd_decoder: RTL and testbench
====================================

// Module: pcecd_cmd_decoder
// PURPOSE
//  Sits downstream of the PC Engine CD bus-phase controller. Consumes command bytes latched in COMMAND phase,
//  sizes the CDB from its opcode, and decodes it into one transfer request for the drive/data stages.
//  Tracks sense for REQUEST SENSE and reports it as a sense-data request; the bus controller owns STATUS/MESSAGE.
// PARAMETERS
//  MAX_CDB_LEN   12   CDB buffer depth in bytes (>= largest supported group length)
//  VENDOR_LEN    10   CDB length for vendor group 6 (0xC0-0xDF)
// PORTS
//  i_clk          in   1   system clock
//  i_rst_n        in   1   synchronous reset, active low
//  i_cmd_phase    in   1   high while bus controller is in COMMAND phase
//  i_byte_valid   in   1   1-cycle strobe: i_byte accepted via REQ/ACK
//  i_byte         in   8   command byte
//  o_cdb_done     out  1   1-cycle pulse: expected byte count reached, stop REQ
//  o_req_valid    out  1   decoded request pending
//  i_req_ack      in   1   consumer takes request (valid&ack)
//  o_req_kind     out  3   0 STATUS_ONLY, 1 READ_SECTORS, 2 SENSE_DATA, 3 AUDIO_CTRL, 4 VENDOR_DATA
//  o_opcode       out  8   CDB byte 0
//  o_lba          out  21  READ(6) LBA = {b1[4:0],b2,b3}
//  o_xfer_len     out  9   READ(6) sectors (0 => 256); else allocation/data bytes
//  o_status       out  8   0x00 GOOD, 0x02 CHECK CONDITION
//  o_sense_key    out  4   current sense key (0 none, 5 illegal request)
//  o_overrun      out  1   sticky: byte strobed outside COLLECT; cleared by reset only
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, byte count 0, sense key 0.
//  FSM IDLE -> COLLECT -> DECODE -> ISSUE -> IDLE.
//  IDLE: i_byte_valid & i_cmd_phase -> store b0 and expected length in 1 cycle, go COLLECT.
//   Length by opcode[7:5]: 0 -> 6; 1,2 -> 10; 5 -> 12; 6 -> VENDOR_LEN; 3,4,7 -> 1 (illegal).
//  COLLECT: each strobe stores at buffer[count] and increments count.
//   When count reaches length: pulse o_cdb_done in the cycle after the last strobe, go DECODE.
//   i_cmd_phase low -> discard buffer, go IDLE, no request; sense unchanged.
//  DECODE, 1 cycle, registers o_* fields:
//   0x00 TEST UNIT READY  -> STATUS_ONLY, GOOD
//   0x08 READ(6)          -> READ_SECTORS, o_xfer_len = b4 ? {1'b0,b4} : 256
//   0x03 REQUEST SENSE    -> SENSE_DATA, o_xfer_len = b4; sense key cleared to 0 on handshake
//   0xD8/0xD9/0xDA        -> AUDIO_CTRL, GOOD
//   0xDD/0xDE             -> VENDOR_DATA, o_xfer_len = 10 (0xDD) / 4 (0xDE)
//   any other opcode      -> STATUS_ONLY, CHECK CONDITION; sense key := 5
//  ISSUE: o_req_valid held with fields stable until i_req_ack. No timeout.
//   Ack in the same cycle valid rises is accepted.
//  Overrun: strobes in DECODE/ISSUE, or with i_cmd_phase low, are dropped and set o_overrun.
//  Any reset cycle returns to IDLE and drops a pending request without a handshake.
//  Count width: clog2(MAX_CDB_LEN+1); lengths never exceed MAX_CDB_LEN.
// STRUCTURE
//  Shared package pcecd_pkg: opcode, req_kind, status and sense-key localparams. Reuse PHASE_* from there.
//  One sub-module, pcecd_cdb_len: combinational opcode -> length lookup.
//  CDB buffer is a flop array; no RAM inference.
// TESTING
//  TUR: bytes 00 00 00 00 00 00 -> o_cdb_done after 6th; req kind 0, status 00; ack clears valid.
//  READ(6): 08 01 23 45 00 00 -> kind 1, lba 0x12345, xfer_len 256; b4=0x10 -> 16.
//  Illegal: byte 0x7F -> cdb_done after 1 byte, status 02, sense 5.
//   Then REQUEST SENSE 03 00 00 00 12 00 -> kind 2, len 18; sense 0 after ack.
//  Abort: 08 01 23, then i_cmd_phase low -> IDLE, no req_valid; next TUR decodes normally.
//  Backpressure/overrun: hold ack low 20 cycles -> fields stable; strobe in ISSUE -> o_overrun=1, req unchanged.
//  Reset: assert i_rst_n=0 mid-COLLECT and in ISSUE -> all outputs 0 next cycle.

Source files
------------

// File: rtl/pcecd_pkg.sv
// Shared opcode, request-kind, status and sense constants for the PC Engine CD command path.
package pcecd_pkg;

  localparam int unsigned MAX_CDB_LEN_DEF = 12;
  localparam int unsigned VENDOR_LEN_DEF  = 10;

  localparam logic [7:0] OP_TUR          = 8'h00;
  localparam logic [7:0] OP_REQ_SENSE    = 8'h03;
  localparam logic [7:0] OP_READ6        = 8'h08;
  localparam logic [7:0] OP_AUDIO_SEARCH = 8'hD8;
  localparam logic [7:0] OP_AUDIO_PLAY   = 8'hD9;
  localparam logic [7:0] OP_AUDIO_PAUSE  = 8'hDA;
  localparam logic [7:0] OP_READ_SUBQ    = 8'hDD;
  localparam logic [7:0] OP_READ_TOC     = 8'hDE;

  localparam logic [2:0] KIND_STATUS_ONLY  = 3'd0;
  localparam logic [2:0] KIND_READ_SECTORS = 3'd1;
  localparam logic [2:0] KIND_SENSE_DATA   = 3'd2;
  localparam logic [2:0] KIND_AUDIO_CTRL   = 3'd3;
  localparam logic [2:0] KIND_VENDOR_DATA  = 3'd4;

  localparam logic [7:0] STATUS_GOOD  = 8'h00;
  localparam logic [7:0] STATUS_CHECK = 8'h02;

  localparam logic [3:0] SENSE_NONE        = 4'd0;
  localparam logic [3:0] SENSE_ILLEGAL_REQ = 4'd5;

  localparam logic [8:0] XFER_SECTORS_256 = 9'd256;
  localparam logic [8:0] XFER_SUBQ        = 9'd10;
  localparam logic [8:0] XFER_TOC         = 9'd4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DECODE  = 2'd2,
    ST_ISSUE   = 2'd3
  } state_t;

  // Decoded transfer request handed to the drive/data stages.
  typedef struct packed {
    logic [2:0]  kind;
    logic [7:0]  opcode;
    logic [20:0] lba;
    logic [8:0]  xfer_len;
    logic [7:0]  status;
  } req_t;

endpackage

// File: rtl/pcecd_cdb_len.sv
// Combinational CDB length lookup from the opcode group (opcode[7:5]).
module pcecd_cdb_len
  import pcecd_pkg::*;
#(
  parameter int unsigned MAX_CDB_LEN = MAX_CDB_LEN_DEF,
  parameter int unsigned VENDOR_LEN  = VENDOR_LEN_DEF,
  parameter int unsigned CNT_W       = $clog2(MAX_CDB_LEN + 1)
) (
  input  logic [2:0]       group_i,
  output logic [CNT_W-1:0] len_o
);

  // Unsupported groups take a single byte so the command is rejected right away.
  always_comb begin
    len_o = CNT_W'(1);
    case (group_i)
      3'd0:       len_o = CNT_W'(6);
      3'd1, 3'd2: len_o = CNT_W'(10);
      3'd5:       len_o = CNT_W'(12);
      3'd6:       len_o = CNT_W'(VENDOR_LEN);
      default:    len_o = CNT_W'(1);
    endcase
  end

endmodule

// File: rtl/pcecd_cmd_decoder.sv
// Collects a CDB during COMMAND phase, decodes it into one transfer request and tracks sense.
module pcecd_cmd_decoder
  import pcecd_pkg::*;
#(
  parameter int unsigned MAX_CDB_LEN = MAX_CDB_LEN_DEF,
  parameter int unsigned VENDOR_LEN  = VENDOR_LEN_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cmd_phase,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic        o_cdb_done,
  output logic        o_req_valid,
  input  logic        i_req_ack,
  output logic [2:0]  o_req_kind,
  output logic [7:0]  o_opcode,
  output logic [20:0] o_lba,
  output logic [8:0]  o_xfer_len,
  output logic [7:0]  o_status,
  output logic [3:0]  o_sense_key,
  output logic        o_overrun
);

  localparam int unsigned CNT_W = $clog2(MAX_CDB_LEN + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] grp_len_c;
  logic [7:0]       cdb_q [MAX_CDB_LEN];
  logic             buf_we_c;
  logic [CNT_W-1:0] buf_idx_c;
  req_t             req_q, req_d;
  logic             req_valid_q, req_valid_d;
  logic             cdb_done_q, cdb_done_d;
  logic [3:0]       sense_q, sense_d;
  logic             overrun_q, overrun_d;
  logic             unused_cdb_c;

  pcecd_cdb_len #(
    .MAX_CDB_LEN (MAX_CDB_LEN),
    .VENDOR_LEN  (VENDOR_LEN),
    .CNT_W       (CNT_W)
  ) u_cdb_len (
    .group_i (i_byte[7:5]),
    .len_o   (grp_len_c)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      len_q       <= '0;
      req_q       <= '0;
      req_valid_q <= 1'b0;
      cdb_done_q  <= 1'b0;
      sense_q     <= SENSE_NONE;
      overrun_q   <= 1'b0;
      for (int unsigned i = 0; i < MAX_CDB_LEN; i++) begin
        cdb_q[CNT_W'(i)] <= '0;
      end
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      len_q       <= len_d;
      req_q       <= req_d;
      req_valid_q <= req_valid_d;
      cdb_done_q  <= cdb_done_d;
      sense_q     <= sense_d;
      overrun_q   <= overrun_d;
      if (buf_we_c) begin
        cdb_q[buf_idx_c] <= i_byte;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    len_d       = len_q;
    req_d       = req_q;
    req_valid_d = req_valid_q;
    cdb_done_d  = 1'b0;
    sense_d     = sense_q;
    overrun_d   = overrun_q;
    buf_we_c    = 1'b0;
    buf_idx_c   = count_q;

    case (state_q)
      ST_IDLE: begin
        if (i_byte_valid && i_cmd_phase) begin
          buf_we_c   = 1'b1;
          buf_idx_c  = '0;
          len_d      = grp_len_c;
          count_d    = CNT_W'(1);
          cdb_done_d = (grp_len_c == CNT_W'(1));
          state_d    = ST_COLLECT;
        end else if (i_byte_valid) begin
          overrun_d = 1'b1;
        end
      end

      ST_COLLECT: begin
        if (!i_cmd_phase) begin
          // Host left COMMAND phase early: drop the partial CDB silently.
          count_d   = '0;
          state_d   = ST_IDLE;
          overrun_d = overrun_q | i_byte_valid;
        end else if (count_q >= len_q) begin
          // Single-byte CDB already complete on entry.
          state_d   = ST_DECODE;
          overrun_d = overrun_q | i_byte_valid;
        end else if (i_byte_valid) begin
          buf_we_c = 1'b1;
          count_d  = count_q + CNT_W'(1);
          if (count_d == len_q) begin
            cdb_done_d = 1'b1;
            state_d    = ST_DECODE;
          end
        end
      end

      ST_DECODE: begin
        req_d        = '0;
        req_d.opcode = cdb_q[0];
        req_d.status = STATUS_GOOD;
        req_d.kind   = KIND_STATUS_ONLY;
        case (cdb_q[0])
          OP_TUR: req_d.kind = KIND_STATUS_ONLY;
          OP_READ6: begin
            req_d.kind     = KIND_READ_SECTORS;
            req_d.lba      = {cdb_q[1][4:0], cdb_q[2], cdb_q[3]};
            req_d.xfer_len = (cdb_q[4] == 8'h00) ? XFER_SECTORS_256 : {1'b0, cdb_q[4]};
          end
          OP_REQ_SENSE: begin
            req_d.kind     = KIND_SENSE_DATA;
            req_d.xfer_len = {1'b0, cdb_q[4]};
          end
          OP_AUDIO_SEARCH, OP_AUDIO_PLAY, OP_AUDIO_PAUSE: req_d.kind = KIND_AUDIO_CTRL;
          OP_READ_SUBQ: begin
            req_d.kind     = KIND_VENDOR_DATA;
            req_d.xfer_len = XFER_SUBQ;
          end
          OP_READ_TOC: begin
            req_d.kind     = KIND_VENDOR_DATA;
            req_d.xfer_len = XFER_TOC;
          end
          default: begin
            req_d.status = STATUS_CHECK;
            sense_d      = SENSE_ILLEGAL_REQ;
          end
        endcase
        req_valid_d = 1'b1;
        count_d     = '0;
        state_d     = ST_ISSUE;
        overrun_d   = overrun_q | i_byte_valid;
      end

      ST_ISSUE: begin
        overrun_d = overrun_q | i_byte_valid;
        if (i_req_ack) begin
          req_valid_d = 1'b0;
          state_d     = ST_IDLE;
          if (req_q.kind == KIND_SENSE_DATA) begin
            sense_d = SENSE_NONE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Trailing CDB bytes are buffered but not interpreted by any supported command.
  always_comb begin
    unused_cdb_c = 1'b0;
    for (int unsigned i = 0; i < MAX_CDB_LEN; i++) begin
      unused_cdb_c = unused_cdb_c ^ (^cdb_q[CNT_W'(i)]);
    end
  end

  assign o_cdb_done  = cdb_done_q;
  assign o_req_valid = req_valid_q;
  assign o_req_kind  = req_q.kind;
  assign o_opcode    = req_q.opcode;
  assign o_lba       = req_q.lba;
  assign o_xfer_len  = req_q.xfer_len;
  assign o_status    = req_q.status;
  assign o_sense_key = sense_q;
  assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_pcecd_cmd_decoder.sv
// Self-checking bench for pcecd_cmd_decoder: directed vector table, random CDBs against a
// behavioural model, and hand-written abort, ack, backpressure, overrun and reset sequences.
module tb_pcecd_cmd_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, cmd_phase, byte_valid, req_ack;
  logic [7:0]  byte_in;
  logic        cdb_done, req_valid, overrun;
  logic [2:0]  req_kind;
  logic [7:0]  opcode, status;
  logic [20:0] lba;
  logic [8:0]  xfer_len;
  logic [3:0]  sense_key;

  pcecd_cmd_decoder dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cmd_phase  (cmd_phase),
    .i_byte_valid (byte_valid),
    .i_byte       (byte_in),
    .o_cdb_done   (cdb_done),
    .o_req_valid  (req_valid),
    .i_req_ack    (req_ack),
    .o_req_kind   (req_kind),
    .o_opcode     (opcode),
    .o_lba        (lba),
    .o_xfer_len   (xfer_len),
    .o_status     (status),
    .o_sense_key  (sense_key),
    .o_overrun    (overrun)
  );

  typedef struct packed {
    logic [7:0]  op, b1, b2, b3, b4;
    logic [3:0]  n;
    logic [2:0]  kind;
    logic [20:0] lba;
    logic [8:0]  xfer;
    logic [7:0]  status;
    logic [3:0]  sv;
    logic [3:0]  sa;
  } vec_t;

  vec_t       vt [12];
  logic [7:0] tx [12];
  logic [7:0] picks [13];
  int         len_tab [8];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         model_sense = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Strobe tx[0..n-1] with random idle gaps; done must pulse only after the last byte.
  task automatic send_tx(input int n, input int max_gap);
    logic early;
    early = 1'b0;
    for (int k = 0; k < n; k++) begin
      byte_in    = tx[k];
      byte_valid = 1'b1;
      tick;
      byte_valid = 1'b0;
      if (k < n - 1) begin
        if (cdb_done) early = 1'b1;
        repeat ($urandom_range(max_gap, 0)) begin
          tick;
          if (cdb_done) early = 1'b1;
        end
      end else begin
        chk("cdb_done_after_last", 32'(cdb_done), 32'd1);
      end
    end
    chk("cdb_done_early", 32'(early), 32'd0);
  endtask

  task automatic wait_valid;
    int w;
    w = 0;
    while (req_valid !== 1'b1 && w < 8) begin
      tick;
      w++;
    end
    chk("req_valid_rise", 32'(req_valid), 32'd1);
  endtask

  task automatic check_req(input logic [2:0] k, input logic [7:0] op, input logic [20:0] l,
                           input logic [8:0] x, input logic [7:0] s, input logic [3:0] sv);
    chk("req_kind", 32'(req_kind), 32'(k));
    chk("opcode",   32'(opcode),   32'(op));
    chk("lba",      32'(lba),      32'(l));
    chk("xfer_len", 32'(xfer_len), 32'(x));
    chk("status",   32'(status),   32'(s));
    chk("sense",    32'(sense_key), 32'(sv));
  endtask

  task automatic do_ack(input int delay, input logic [3:0] sa);
    logic dropped;
    dropped = 1'b0;
    repeat (delay) begin
      tick;
      if (!req_valid) dropped = 1'b1;
    end
    chk("valid_held_before_ack", 32'(dropped), 32'd0);
    req_ack = 1'b1;
    tick;
    req_ack = 1'b0;
    chk("valid_after_ack", 32'(req_valid), 32'd0);
    chk("sense_after_ack", 32'(sense_key), 32'(sa));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_cdb_done"},  32'(cdb_done),  32'd0);
    chk({tag, "_req_valid"}, 32'(req_valid), 32'd0);
    chk({tag, "_kind"},      32'(req_kind),  32'd0);
    chk({tag, "_opcode"},    32'(opcode),    32'd0);
    chk({tag, "_lba"},       32'(lba),       32'd0);
    chk({tag, "_xfer"},      32'(xfer_len),  32'd0);
    chk({tag, "_status"},    32'(status),    32'd0);
    chk({tag, "_sense"},     32'(sense_key), 32'd0);
    chk({tag, "_overrun"},   32'(overrun),   32'd0);
  endtask

  // Behavioural model: expected request fields straight from the command rules.
  task automatic model(output int n, output logic [2:0] k, output logic [20:0] l,
                       output logic [8:0] x, output logic [7:0] s,
                       output logic [3:0] sv, output logic [3:0] sa);
    int op, kind_i, lba_i, xfer_i, st_i;
    op     = int'(tx[0]);
    n      = len_tab[op / 32];
    kind_i = 0; lba_i = 0; xfer_i = 0; st_i = 0;
    if (op == 8'h00) begin
      kind_i = 0;
    end else if (op == 8'h08) begin
      kind_i = 1;
      lba_i  = (int'(tx[1]) % 32) * 65536 + int'(tx[2]) * 256 + int'(tx[3]);
      xfer_i = (tx[4] == 8'h00) ? 256 : int'(tx[4]);
    end else if (op == 8'h03) begin
      kind_i = 2;
      xfer_i = int'(tx[4]);
    end else if (op == 8'hD8 || op == 8'hD9 || op == 8'hDA) begin
      kind_i = 3;
    end else if (op == 8'hDD) begin
      kind_i = 4; xfer_i = 10;
    end else if (op == 8'hDE) begin
      kind_i = 4; xfer_i = 4;
    end else begin
      st_i = 2;
    end
    if (st_i == 2) model_sense = 5;
    sv = 4'(model_sense);
    if (kind_i == 2) model_sense = 0;
    sa = 4'(model_sense);
    k  = 3'(kind_i);
    l  = 21'(lba_i);
    x  = 9'(xfer_i);
    s  = 8'(st_i);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          n;
    logic [2:0]  ek;
    logic [20:0] el;
    logic [8:0]  ex;
    logic [7:0]  es;
    logic [3:0]  esv, esa;
    logic        bad;

    len_tab = '{6, 10, 10, 1, 1, 12, 10, 1};
    picks   = '{8'h00, 8'h08, 8'h03, 8'hD8, 8'hD9, 8'hDA, 8'hDD, 8'hDE,
                8'h7F, 8'h12, 8'h28, 8'hA8, 8'hC5};
    //         op     b1     b2     b3     b4     n   kind  lba         xfer   status sv sa
    vt[0]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'd6,  3'd0, 21'h0,      9'd0,   8'h00, 4'd0, 4'd0};
    vt[1]  = '{8'h08, 8'h01, 8'h23, 8'h45, 8'h00, 4'd6,  3'd1, 21'h12345,  9'd256, 8'h00, 4'd0, 4'd0};
    vt[2]  = '{8'h08, 8'h01, 8'h23, 8'h45, 8'h10, 4'd6,  3'd1, 21'h12345,  9'd16,  8'h00, 4'd0, 4'd0};
    vt[3]  = '{8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 4'd1,  3'd0, 21'h0,      9'd0,   8'h02, 4'd5, 4'd5};
    vt[4]  = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h12, 4'd6,  3'd2, 21'h0,      9'd18,  8'h00, 4'd5, 4'd0};
    vt[5]  = '{8'hD9, 8'h00, 8'h00, 8'h00, 8'h00, 4'd10, 3'd3, 21'h0,      9'd0,   8'h00, 4'd0, 4'd0};
    vt[6]  = '{8'hDD, 8'h00, 8'h00, 8'h00, 8'h00, 4'd10, 3'd4, 21'h0,      9'd10,  8'h00, 4'd0, 4'd0};
    vt[7]  = '{8'hDE, 8'h00, 8'h00, 8'h00, 8'h00, 4'd10, 3'd4, 21'h0,      9'd4,   8'h00, 4'd0, 4'd0};
    vt[8]  = '{8'h12, 8'h00, 8'h00, 8'h00, 8'h24, 4'd6,  3'd0, 21'h0,      9'd0,   8'h02, 4'd5, 4'd5};
    vt[9]  = '{8'h28, 8'h00, 8'h00, 8'h00, 8'h00, 4'd10, 3'd0, 21'h0,      9'd0,   8'h02, 4'd5, 4'd5};
    vt[10] = '{8'hA8, 8'h00, 8'h00, 8'h00, 8'h00, 4'd12, 3'd0, 21'h0,      9'd0,   8'h02, 4'd5, 4'd5};
    vt[11] = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h20, 4'd6,  3'd2, 21'h0,      9'd32,  8'h00, 4'd5, 4'd0};

    rst_n = 1'b0; cmd_phase = 1'b1; byte_valid = 1'b0; req_ack = 1'b0; byte_in = 8'h00;
    repeat (3) tick;
    check_zero("reset");
    rst_n = 1'b1;
    tick;

    // Directed vector table
    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < 12; k++) tx[k] = 8'h00;
      tx[0] = vt[r].op; tx[1] = vt[r].b1; tx[2] = vt[r].b2; tx[3] = vt[r].b3; tx[4] = vt[r].b4;
      send_tx(int'(vt[r].n), 1);
      wait_valid;
      check_req(vt[r].kind, vt[r].op, vt[r].lba, vt[r].xfer, vt[r].status, vt[r].sv);
      do_ack($urandom_range(2, 0), vt[r].sa);
    end
    chk("overrun_clean", 32'(overrun), 32'd0);

    // Random CDBs against the model
    model_sense = 0;
    for (int c = 0; c < 40; c++) begin
      int pick;
      for (int k = 0; k < 12; k++) tx[k] = 8'($urandom);
      pick = $urandom_range(13, 0);
      if (pick < 13) tx[0] = picks[pick];
      if ($urandom_range(3, 0) == 0) tx[4] = 8'h00;
      model(n, ek, el, ex, es, esv, esa);
      send_tx(n, 2);
      wait_valid;
      check_req(ek, tx[0], el, ex, es, esv);
      do_ack($urandom_range(3, 0), esa);
    end

    // Abort mid-collection, then a normal TUR
    tx[0] = 8'h08; tx[1] = 8'h01; tx[2] = 8'h23;
    for (int k = 0; k < 3; k++) begin
      byte_in = tx[k]; byte_valid = 1'b1; tick; byte_valid = 1'b0;
    end
    cmd_phase = 1'b0;
    bad = 1'b0;
    repeat (10) begin
      tick;
      if (req_valid || cdb_done) bad = 1'b1;
    end
    chk("abort_no_request", 32'(bad), 32'd0);
    chk("abort_sense_kept", 32'(sense_key), 32'(model_sense));
    cmd_phase = 1'b1;
    tick;
    for (int k = 0; k < 12; k++) tx[k] = 8'h00;
    send_tx(6, 0);
    wait_valid;
    check_req(3'd0, 8'h00, 21'h0, 9'd0, 8'h00, 4'(model_sense));
    do_ack(0, 4'(model_sense));

    // Ack already high when valid rises
    tx[0] = 8'hDA;
    send_tx(10, 0);
    req_ack = 1'b1;
    wait_valid;
    tick;
    chk("same_cycle_ack", 32'(req_valid), 32'd0);
    req_ack = 1'b0;
    tick;

    // Backpressure and overrun in ISSUE
    tx[0] = 8'h08; tx[1] = 8'hFF; tx[2] = 8'hFF; tx[3] = 8'hFF; tx[4] = 8'h10;
    send_tx(6, 0);
    wait_valid;
    bad = 1'b0;
    repeat (20) begin
      tick;
      if (!req_valid || req_kind != 3'd1 || lba != 21'h1FFFFF || xfer_len != 9'd16 ||
          opcode != 8'h08 || status != 8'h00) bad = 1'b1;
    end
    chk("hold_stable", 32'(bad), 32'd0);
    byte_in = 8'hAA; byte_valid = 1'b1; tick; byte_valid = 1'b0;
    chk("overrun_set", 32'(overrun), 32'd1);
    chk("overrun_valid_kept", 32'(req_valid), 32'd1);
    check_req(3'd1, 8'h08, 21'h1FFFFF, 9'd16, 8'h00, 4'(model_sense));
    do_ack(1, 4'(model_sense));
    chk("overrun_sticky", 32'(overrun), 32'd1);

    // Reset mid-collection
    tx[0] = 8'h08; tx[1] = 8'h01;
    for (int k = 0; k < 2; k++) begin
      byte_in = tx[k]; byte_valid = 1'b1; tick; byte_valid = 1'b0;
    end
    rst_n = 1'b0;
    tick;
    check_zero("rst_collect");
    rst_n = 1'b1;
    tick;

    // Reset with a request pending
    tx[0] = 8'h7F;
    send_tx(1, 0);
    wait_valid;
    chk("issue_sense_before_rst", 32'(sense_key), 32'd5);
    rst_n = 1'b0;
    tick;
    check_zero("rst_issue");
    rst_n = 1'b1;
    tick;

    // Decoder is usable after reset
    for (int k = 0; k < 12; k++) tx[k] = 8'h00;
    send_tx(6, 0);
    wait_valid;
    check_req(3'd0, 8'h00, 21'h0, 9'd0, 8'h00, 4'd0);
    do_ack(0, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
